// File: rtl/run_sequencer.sv
// Run controller for the 9-bit processor: converts the bench Start handshake
// into program launches, gates core execution and reports Done/Timeout.
module run_sequencer #(
  parameter int unsigned    A       = 10,
  parameter int unsigned    NPROG   = 3,
  parameter int unsigned    BASE0   = 0,
  parameter int unsigned    BASE1   = 100,
  parameter int unsigned    BASE2   = 200,
  parameter int unsigned    BASE3   = 300,
  parameter int unsigned    CW      = 16,
  parameter logic [CW-1:0]  TIMEOUT = 16'd50000
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          HaltReq,
  output logic          PcLoad,
  output logic [A-1:0]  PcLoadAddr,
  output logic          CoreEn,
  output logic          Done,
  output logic          Timeout,
  output logic [1:0]    ProgIdx,
  output logic [CW-1:0] CycleCount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] state;
  logic       start_r;
  logic [1:0] next_idx;
  logic [1:0] next_idx_inc;
  logic       timeout_r;
  logic       rise;
  logic       fall;

  assign rise = Start & ~start_r;
  assign fall = ~Start & start_r;

  assign next_idx_inc = (next_idx == 2'(NPROG - 1)) ? '0 : next_idx + 2'd1;

  always_comb begin
    PcLoadAddr = A'(BASE0);
    case (ProgIdx)
      2'd1:    PcLoadAddr = A'(BASE1);
      2'd2:    PcLoadAddr = A'(BASE2);
      2'd3:    PcLoadAddr = A'(BASE3);
      default: PcLoadAddr = A'(BASE0);
    endcase
  end

  // Outputs decode from registered state only; Timeout is reported only in DONE.
  assign PcLoad  = (state == S_LOAD);
  assign CoreEn  = (state == S_RUN);
  assign Done    = (state == S_DONE);
  assign Timeout = timeout_r & (state == S_DONE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      start_r    <= 1'b0;
      next_idx   <= '0;
      ProgIdx    <= '0;
      CycleCount <= '0;
      timeout_r  <= 1'b0;
    end else begin
      start_r <= Start;
      case (state)
        S_IDLE, S_DONE: begin
          if (rise) begin
            ProgIdx  <= next_idx;
            next_idx <= next_idx_inc;
            state    <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (fall) state <= S_LOAD;
        end
        S_LOAD: begin
          CycleCount <= '0;
          timeout_r  <= 1'b0;
          state      <= S_RUN;
        end
        S_RUN: begin
          CycleCount <= CycleCount + 1'b1;
          // Halt takes priority over the cycle limit landing on the same edge.
          if (HaltReq) begin
            state <= S_DONE;
          end else if (CycleCount == TIMEOUT - 1'b1) begin
            state     <= S_DONE;
            timeout_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with TIMEOUT=8 and three programs.
module tb_run_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic        HaltReq;
  logic        PcLoad;
  logic [9:0]  PcLoadAddr;
  logic        CoreEn;
  logic        Done;
  logic        Timeout;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;

  int n_vec = 0;
  int n_bad = 0;

  run_sequencer #(
    .A(10), .NPROG(3), .BASE0(0), .BASE1(100), .BASE2(200), .BASE3(300),
    .CW(16), .TIMEOUT(16'd8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .HaltReq(HaltReq),
    .PcLoad(PcLoad), .PcLoadAddr(PcLoadAddr), .CoreEn(CoreEn), .Done(Done),
    .Timeout(Timeout), .ProgIdx(ProgIdx), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start high for two sampled edges, then low; checks ARMED, LOAD and RUN entry.
  task automatic launch(input logic [1:0] idx, input logic [9:0] addr);
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1;
    chk("armed_progidx", ProgIdx, idx);
    chk("armed_done", Done, 0);
    chk("armed_pcload", PcLoad, 0);
    @(posedge Clk); #1 Start = 1'b0;
    @(posedge Clk); #1;
    chk("load_pcload", PcLoad, 1);
    chk("load_addr", PcLoadAddr, addr);
    chk("load_coreen", CoreEn, 0);
    @(posedge Clk); #1;
    chk("run_coreen", CoreEn, 1);
    chk("run_pcload", PcLoad, 0);
  endtask

  // Counts RUN cycles from 'first'; asserts HaltReq in RUN cycle 'halt' (0 = never).
  task automatic run_phase(input int first, input int halt, input int exp_cnt, input logic exp_to);
    int n = first - 1;
    while (CoreEn && n < 50) begin
      n++;
      if (n == halt) HaltReq = 1'b1;
      @(posedge Clk); #1 HaltReq = 1'b0;
    end
    chk("run_cycles", n, exp_cnt);
    chk("done", Done, 1);
    chk("done_coreen", CoreEn, 0);
    chk("cyclecount", CycleCount, exp_cnt);
    chk("timeout", Timeout, exp_to);
  endtask

  initial begin
    int bad_idle = 0;
    Reset_n = 1'b0; Start = 1'b0; HaltReq = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_coreen", CoreEn, 0);
    chk("rst_done", Done, 0);
    chk("rst_pcload", PcLoad, 0);
    chk("rst_cyclecount", CycleCount, 0);
    @(negedge Clk) Reset_n = 1'b1;

    // Idle for 20 cycles; a stray HaltReq must have no effect.
    for (int i = 0; i < 20; i++) begin
      HaltReq = (i >= 5 && i < 8);
      @(negedge Clk);
      if (CoreEn || PcLoad || Done || Timeout) bad_idle++;
    end
    HaltReq = 1'b0;
    chk("idle_quiet", bad_idle, 0);
    chk("idle_progidx", ProgIdx, 0);
    chk("idle_addr", PcLoadAddr, 0);

    launch(2'd0, 10'd0);   run_phase(1, 5, 5, 1'b0);
    launch(2'd1, 10'd100); run_phase(1, 3, 3, 1'b0);
    launch(2'd2, 10'd200); run_phase(1, 8, 8, 1'b0);  // halt on the timeout cycle
    launch(2'd0, 10'd0);   run_phase(1, 0, 8, 1'b1);  // cycle limit

    // Start pulse during RUN is ignored and does not consume an index.
    launch(2'd1, 10'd100);
    Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    @(posedge Clk); #1;
    chk("pulse_coreen", CoreEn, 1);
    chk("pulse_progidx", ProgIdx, 1);
    run_phase(3, 4, 4, 1'b0);
    launch(2'd2, 10'd200);

    // Asynchronous reset mid-RUN.
    #2 Reset_n = 1'b0;
    #1;
    chk("async_coreen", CoreEn, 0);
    chk("async_progidx", ProgIdx, 0);
    chk("async_cyclecount", CycleCount, 0);
    @(negedge Clk) Reset_n = 1'b1;
    launch(2'd0, 10'd0);   run_phase(1, 2, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Top-level run controller for the 9-bit processor. It turns the test bench's Start handshake into program launches and drives a one-cycle PC load to the selected program's base address. It gates core execution and counts cycles, and reports Done or Timeout back to the bench. It sits between the bench and the program counter, decode, and register-file write enables, and is the only block that decides when the core runs.

## Interface
Parameters:
- A, 10, instruction address width (matches PC width)
- NPROG, 3, number of programs in the series (1..4)
- BASE0, 0, start address of program 0
- BASE1, 100, start address of program 1
- BASE2, 200, start address of program 2
- BASE3, 300, start address of program 3 (used only if NPROG=4)
- CW, 16, cycle-counter width
- TIMEOUT, 16'd50000, RUN-cycle limit before forced stop (1..2^CW-1)

Ports:
- Clk  in  1  single clock; all state changes on posedge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  bench request level, synchronous to Clk
- HaltReq  in  1  decode saw the halt instruction; meaningful only in RUN
- PcLoad  out  1  one-cycle pulse: PC loads PcLoadAddr on next edge
- PcLoadAddr  out  A  base address of the selected program
- CoreEn  out  1  high only in RUN; gates PC increment, branches and writes
- Done  out  1  level; high in DONE
- Timeout  out  1  high in DONE when the run ended by cycle limit
- ProgIdx  out  2  index of the current or last launched program
- CycleCount  out  CW  RUN cycles of the current or last program

## Operation
- Edge detect: start_r <= Start each cycle. rise = Start & ~start_r. fall = ~Start & start_r.
- NextIdx: internal 2-bit register, reset 0.
- States: IDLE, ARMED, LOAD, RUN, DONE. Encoding is free.
- IDLE: all outputs 0. On rise: ProgIdx <= NextIdx, NextIdx advances (NPROG-1 wraps to 0), go to ARMED.
- ARMED: wait for fall, then go to LOAD. Further rises are impossible while Start stays high.
- LOAD: PcLoad=1, PcLoadAddr=BASE[ProgIdx], CycleCount <= 0, Timeout <= 0. Next state is always RUN.
- RUN: CoreEn=1, CycleCount increments each cycle.
  - HaltReq=1 -> DONE.
  - Otherwise CycleCount==TIMEOUT-1 -> DONE with Timeout <= 1.
- DONE: Done=1, CoreEn=0. CycleCount and Timeout hold. On rise: update ProgIdx and NextIdx as in IDLE, Done drops, go to ARMED.
- PcLoadAddr is BASE[ProgIdx] in every state. It is valid whenever PcLoad=1.
- rise during ARMED, LOAD or RUN: ignored, NextIdx unchanged.
- HaltReq outside RUN: ignored.
- HaltReq and timeout in the same cycle: HaltReq wins, Timeout stays 0.
- CycleCount never exceeds TIMEOUT, so it cannot wrap.
- NPROG=1: NextIdx stays 0, and every launch goes to BASE0.

## Timing
- Reset (Reset_n low, asynchronous, any state):
  - State=IDLE.
  - start_r, NextIdx, ProgIdx, CycleCount = 0.
  - PcLoad, CoreEn, Done, Timeout = 0.
- Release: first state change is possible on the first posedge with Reset_n high.
- Launch latency, with Start high at edge t and low at edge t+k:
  - ARMED after edge t.
  - LOAD (PcLoad high) during cycle after edge t+k.
  - RUN (CoreEn high, PC=base) after edge t+k+1.
- Halt latency: HaltReq high in RUN at edge h -> DONE and Done high after edge h. CoreEn is low in that same cycle.
- CycleCount: equals the number of RUN cycles, including the cycle in which HaltReq was sampled.
- Timeout stop: DONE with CycleCount=TIMEOUT after exactly TIMEOUT RUN cycles.
- Done to next launch: Done falls on the edge that samples the rise of Start.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: hold Reset_n low 3 cycles, release, Start=0 for 20 cycles -> CoreEn, PcLoad, Done stay 0; ProgIdx=0.
- Launch program 0: Start high 2 cycles then low; HaltReq after 5 RUN cycles -> PcLoad one cycle with PcLoadAddr=0; CoreEn high 5 cycles; Done=1; CycleCount=5; Timeout=0.
- Series of 4 launches, NPROG=3:
  - ProgIdx sequence is 0,1,2,0.
  - PcLoadAddr sequence is 0,100,200,0.
  - Done drops on each new Start rise.
- Timeout with TIMEOUT=8, HaltReq never asserted -> Done=1, Timeout=1, CycleCount=8, CoreEn high exactly 8 cycles.
- HaltReq and timeout together: TIMEOUT=8, HaltReq in RUN cycle 8 -> Done=1, Timeout=0, CycleCount=8.
- Abuse:
  - Start pulse during RUN -> ignored; next launch still uses the next index.
  - Reset_n low mid-RUN -> CoreEn drops immediately, asynchronously.
  - After release, the next launch uses ProgIdx=0.
